// File: rtl/debug_unlock_pkg.sv
// Shared types and default parameters for the debug-unlock controller.
// Timer width helper sizes one counter for both the unlock and backoff windows.
package debug_unlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    UNLOCKED,
    BACKOFF,
    LOCKOUT
  } state_t;

  localparam int          DEF_KEY_W          = 16;
  localparam logic [15:0] DEF_UNLOCK_KEY     = 16'hA5C3;
  localparam int          DEF_MAX_FAIL       = 3;
  localparam int          DEF_UNLOCK_CYCLES  = 1024;
  localparam int          DEF_BACKOFF_CYCLES = 64;

  function automatic int timer_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/unlock_timer.sv
// Loadable down-counter; load wins over enable, counting stops at zero.
// zero is a combinational decode of the registered count.
module unlock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/debug_unlock_ctrl.sv
// Key-gated debug unlock with fail counting, backoff and terminal lockout; sticky config lock.
// Key accept -> debug_mode one cycle later; key_ready low (no capture) whenever not IDLE.
module debug_unlock_ctrl
  import debug_unlock_pkg::*;
#(
  parameter int               KEY_W          = DEF_KEY_W,
  parameter logic [KEY_W-1:0] UNLOCK_KEY     = DEF_UNLOCK_KEY,
  parameter int               MAX_FAIL       = DEF_MAX_FAIL,
  parameter int               UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int               BACKOFF_CYCLES = DEF_BACKOFF_CYCLES
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            key_valid,
  output logic                            key_ready,
  input  logic [KEY_W-1:0]                key_data,
  input  logic                            relock,
  input  logic                            lock_cfg_done,
  output logic                            lock_out,
  output logic                            debug_mode,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = timer_width(UNLOCK_CYCLES, BACKOFF_CYCLES);

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] BACKOFF_LOAD = TW'(BACKOFF_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);

  state_t          state;
  state_t          state_nxt;
  logic [KEY_W-1:0] key_q;
  logic [FW-1:0]   fail_nxt;
  logic            key_match;
  logic            timer_load;
  logic [TW-1:0]   timer_load_val;
  logic            timer_en;
  logic            timer_zero;

  assign key_ready = (state == IDLE);
  assign key_match = (key_q == UNLOCK_KEY);

  unlock_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_comb begin
    state_nxt      = state;
    fail_nxt       = fail_cnt;
    timer_load     = 1'b0;
    timer_load_val = UNLOCK_LOAD;
    timer_en       = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (key_match) begin
          fail_nxt       = '0;
          timer_load     = 1'b1;
          timer_load_val = UNLOCK_LOAD;
          state_nxt      = UNLOCKED;
        end else begin
          // Saturating increment: the count can never wrap past MAX_FAIL.
          if (fail_cnt != FAIL_MAX) begin
            fail_nxt = fail_cnt + FW'(1);
          end
          if (fail_nxt == FAIL_MAX) begin
            state_nxt = LOCKOUT;
          end else begin
            timer_load     = 1'b1;
            timer_load_val = BACKOFF_LOAD;
            state_nxt      = BACKOFF;
          end
        end
      end
      UNLOCKED: begin
        if (relock || timer_zero) begin
          state_nxt = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      BACKOFF: begin
        if (timer_zero) begin
          state_nxt = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      LOCKOUT: begin
        state_nxt = LOCKOUT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are registered from next-state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      fail_cnt   <= '0;
      key_q      <= '0;
      debug_mode <= 1'b0;
      lockout    <= 1'b0;
      lock_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fail_cnt   <= fail_nxt;
      debug_mode <= (state_nxt == UNLOCKED);
      lockout    <= (state_nxt == LOCKOUT);
      lock_out   <= lock_out | lock_cfg_done;
      if (key_valid && key_ready) begin
        key_q <= key_data;
      end
    end
  end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Bench for debug_unlock_ctrl: vector table, directed multi-cycle sequences and a random run
// checked every cycle against a time-window reference model.
module tb_debug_unlock_ctrl;

  localparam int          KEY_W = 16;
  localparam logic [15:0] KEY   = 16'hA5C3;
  localparam int          MF    = 3;
  localparam int          UC    = 1024;
  localparam int          BC    = 64;
  localparam longint      INF   = 64'd1 << 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_data;
  logic        relock;
  logic        lock_cfg_done;
  logic        lock_out;
  logic        debug_mode;
  logic        lockout;
  logic [1:0]  fail_cnt;

  always #5 clk = ~clk;

  debug_unlock_ctrl #(
    .KEY_W(KEY_W), .UNLOCK_KEY(KEY), .MAX_FAIL(MF),
    .UNLOCK_CYCLES(UC), .BACKOFF_CYCLES(BC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key_data      (key_data),
    .relock        (relock),
    .lock_cfg_done (lock_cfg_done),
    .lock_out      (lock_out),
    .debug_mode    (debug_mode),
    .lockout       (lockout),
    .fail_cnt      (fail_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: windows of edge indices rather than states.
  longint e = 0;
  longint ready_at, dbg_lo, dbg_hi, lo_at, pend_t;
  int     fails, pend_v;
  bit     lk, m_ready, m_dbg, m_lo;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, e, act, exp);
    end
  endtask

  task automatic model_reset();
    ready_at = 0; dbg_lo = 1; dbg_hi = 0; lo_at = INF; pend_t = -1;
    fails = 0; pend_v = 0; lk = 0;
    m_ready = 1; m_dbg = 0; m_lo = 0;
  endtask

  task automatic model_edge();
    bit acc, rl;
    if (!resetn) begin
      model_reset();
      return;
    end
    acc = m_ready && key_valid;
    rl  = m_dbg && relock;
    if (pend_t == e) fails = pend_v;
    if (acc) begin
      pend_t = e + 1;
      if (key_data == KEY) begin
        dbg_lo = e + 1; dbg_hi = e + UC; ready_at = e + 1 + UC; pend_v = 0;
      end else begin
        pend_v = (fails < MF) ? fails + 1 : MF;
        if (pend_v >= MF) begin
          lo_at = e + 1; ready_at = INF;
        end else begin
          ready_at = e + 1 + BC;
        end
      end
    end
    if (rl) begin
      dbg_hi = e - 1; ready_at = e;
    end
    if (lock_cfg_done) lk = 1;
    m_lo    = (lo_at <= e);
    m_ready = !m_lo && (e >= ready_at);
    m_dbg   = (e >= dbg_lo) && (e <= dbg_hi);
  endtask

  task automatic check_all(string nm);
    chk(nm, {26'd0, key_ready, debug_mode, lockout, lock_out, fail_cnt},
            {26'd0, m_ready, m_dbg, m_lo, lk, fails[1:0]});
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check_all("model");
  endtask

  task automatic async_reset(string nm);
    #3 resetn = 1'b0;
    #2;
    model_reset();
    check_all(nm);
    step();
    resetn = 1'b1;
  endtask

  task automatic wait_ready(int budget);
    int n = 0;
    while (!key_ready && n < budget) begin
      step();
      n++;
    end
    chk("wait_ready", key_ready, 1);
  endtask

  typedef struct {
    logic v; logic [15:0] k; logic rl; logic lcd;
    logic rdy; logic dbg; logic lo; logic [1:0] fc; logic lk;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cnt;
    bit seen_dbg, seen_rdy;

    tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 16'hA5C3, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1};

    resetn = 1'b0; key_valid = 1'b0; key_data = '0; relock = 1'b0; lock_cfg_done = 1'b0;
    model_reset();
    #2;
    chk("reset_outputs", {key_ready, debug_mode, lockout, lock_out, fail_cnt}, 6'b100000);
    step(); step();
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      key_valid = tbl[i].v; key_data = tbl[i].k; relock = tbl[i].rl; lock_cfg_done = tbl[i].lcd;
      step();
      chk($sformatf("tbl_row%0d", i),
          {key_ready, debug_mode, lockout, lock_out, fail_cnt},
          {tbl[i].rdy, tbl[i].dbg, tbl[i].lo, tbl[i].lk, tbl[i].fc});
    end
    key_valid = 1'b0; relock = 1'b0; lock_cfg_done = 1'b0;
    async_reset("reset_after_tbl");

    // Bad key, then a good key held through backoff.
    key_valid = 1'b1; key_data = 16'h0000;
    step();
    key_data = KEY;
    cnt = 1;
    for (int i = 0; i < 200 && !key_ready; i++) begin
      step();
      if (!key_ready) cnt++;
    end
    chk("backoff_low_cycles", cnt, BC + 1);
    chk("bad_key_fail_cnt", fail_cnt, 1);
    step();
    key_valid = 1'b0;
    step();
    chk("held_key_unlock", debug_mode, 1);
    async_reset("reset_after_held");

    // Full unlock window.
    key_valid = 1'b1; key_data = KEY;
    step();
    key_valid = 1'b0;
    step();
    cnt = debug_mode ? 1 : 0;
    for (int i = 0; i < 2000 && debug_mode; i++) begin
      step();
      if (debug_mode) cnt++;
    end
    chk("unlock_window_len", cnt, UC);
    chk("unlock_end_ready", key_ready, 1);
    chk("unlock_fail_cnt", fail_cnt, 0);

    // Lock request and relock inside a window.
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    step();
    repeat (4) step();
    lock_cfg_done = 1'b1;
    step();
    lock_cfg_done = 1'b0;
    chk("lcd_lock_out", lock_out, 1);
    chk("lcd_window_kept", debug_mode, 1);
    repeat (3) step();
    relock = 1'b1;
    step();
    relock = 1'b0;
    chk("relock_dbg_low", debug_mode, 0);
    chk("relock_idle", key_ready, 1);
    step();
    chk("relock_keeps_lock", lock_out, 1);

    // Three bad keys -> terminal lockout.
    for (int i = 0; i < 3; i++) begin
      wait_ready(200);
      key_valid = 1'b1; key_data = 16'h1234;
      step();
      key_valid = 1'b0;
      step();
      chk($sformatf("bad%0d_fail_cnt", i + 1), fail_cnt, i + 1);
    end
    chk("lockout_set", lockout, 1);
    key_valid = 1'b1; key_data = KEY;
    seen_dbg = 0; seen_rdy = 0;
    repeat (100) begin
      step();
      seen_dbg |= debug_mode;
      seen_rdy |= key_ready;
    end
    key_valid = 1'b0;
    chk("lockout_no_unlock", {seen_dbg, seen_rdy}, 0);
    async_reset("reset_clears_lockout");
    chk("lockout_cleared", {lockout, fail_cnt, lock_out}, 0);

    // Asynchronous reset in the middle of an unlock window.
    key_valid = 1'b1; key_data = KEY;
    step();
    key_valid = 1'b0;
    repeat (100) step();
    chk("mid_unlock_dbg", debug_mode, 1);
    async_reset("async_mid_unlock");
    chk("async_mid_unlock_dbg", debug_mode, 0);

    // Random traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      key_valid     = ($urandom_range(0, 3) == 0);
      key_data      = ($urandom_range(0, 2) == 0) ? KEY : 16'($urandom);
      relock        = ($urandom_range(0, 63) == 0);
      lock_cfg_done = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        async_reset("rand_reset");
      end else begin
        step();
      end
    end
    key_valid = 1'b0; relock = 1'b0; lock_cfg_done = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_unlock_ctrl.md
# debug_unlock_ctrl

Key-gated debug-unlock and lock-request controller sitting directly upstream of the lock-protected configuration register. It drives that register's `Lock` and `debug_mode` inputs, so the debug override is granted only after a correct key is presented, for a bounded window. Failed attempts are counted, each one incurs a backoff delay, and repeated failures force a terminal lockout that only reset clears.

## Interface
- `KEY_W`, 16: key width.
- `UNLOCK_KEY`, 16'hA5C3: expected key value (KEY_W bits).
- `MAX_FAIL`, 3: failed attempts before terminal lockout; must be ≥1.
- `UNLOCK_CYCLES`, 1024: cycles `debug_mode` stays high per unlock; must be ≥1.
- `BACKOFF_CYCLES`, 64: cycles with `key_ready` low after a failed attempt; must be ≥1.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  key presented.
- `key_ready`  out  1  controller can accept a key.
- `key_data`  in  KEY_W  key value.
- `relock`  in  1  software request to end the unlock window early.
- `lock_cfg_done`  in  1  firmware finished configuration; requests a permanent lock.
- `lock_out`  out  1  drives downstream `Lock`; sticky.
- `debug_mode`  out  1  drives downstream `debug_mode`.
- `lockout`  out  1  terminal lockout status.
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  failed-attempt count.

## Operation
- **Reset values:**
  - state IDLE.
  - `key_ready`=1 (combinational decode of IDLE).
  - `debug_mode`=0, `lock_out`=0, `lockout`=0, `fail_cnt`=0.
  - timer=0, captured key=0.
- **IDLE:** `key_ready`=1. When `key_valid & key_ready`, capture `key_data` and go to CHECK.
- **CHECK** (always exactly 1 cycle):
  - Captured key == UNLOCK_KEY: `fail_cnt`←0, timer←UNLOCK_CYCLES-1, go to UNLOCKED.
  - Otherwise: `fail_cnt`←`fail_cnt`+1.
    - New count == MAX_FAIL: go to LOCKOUT.
    - Else: timer←BACKOFF_CYCLES-1, go to BACKOFF.
- **UNLOCKED:** `debug_mode`=1.
  - `relock`=1: go to IDLE. This has priority over the timer.
  - Else timer==0: go to IDLE.
  - Else timer decrements.
- **BACKOFF:** timer==0: go to IDLE. Else timer decrements.
- **LOCKOUT:** terminal until reset. `lockout`=1; `key_ready`=0 and `debug_mode`=0 permanently.
- **`key_ready`:** 0 in CHECK, UNLOCKED, BACKOFF and LOCKOUT. A `key_valid` in those states is not accepted, and the key is not captured.
- **`relock`:** ignored outside UNLOCKED.
- **`lock_out`:**
  - Set on any cycle with `lock_cfg_done`=1; cleared only by reset.
  - Independent of FSM state. A successful unlock does not clear it.
- **`fail_cnt`:** saturates at MAX_FAIL and never wraps.
- **Compare:** full-width equality only; no partial-match information is exposed.

## Timing
- `debug_mode` and `lockout` are registered, decoded from next-state so they are glitch-free.
- **Accept to `debug_mode` rising:** key accepted at edge N enters CHECK. At edge N+1 the FSM enters UNLOCKED and `debug_mode` rises.
- **Unlock window:** `debug_mode` stays high for exactly UNLOCK_CYCLES cycles and falls at edge N+1+UNLOCK_CYCLES.
- **Relock:** `relock` sampled high at edge M during UNLOCKED drops `debug_mode` at edge M.
- **Failed key:**
  - A key accepted at edge N updates `fail_cnt` at edge N+1.
  - `key_ready` returns high at edge N+1+BACKOFF_CYCLES.
  - When that update reaches MAX_FAIL, `lockout` rises at edge N+1.
- **`lock_cfg_done`:** high at edge K gives `lock_out`=1 from edge K.
- **Reset mid-operation:** asynchronous assertion immediately returns every output to its reset value, including clearing `debug_mode` within an unlock window and clearing `lockout`.

## Structure
- **Package `debug_unlock_pkg`:**
  - `state_t` enum: IDLE, CHECK, UNLOCKED, BACKOFF, LOCKOUT.
  - Default-parameter constants.
- **Sub-module `unlock_timer`:**
  - Loadable down-counter, width $clog2(max(UNLOCK_CYCLES, BACKOFF_CYCLES)).
  - Ports: `load`, `load_val`, `en`, `zero`.
  - Reused for both the UNLOCKED and BACKOFF windows.

## Test plan
- **Correct key:** reset, then key 16'hA5C3 accepted at edge N → `debug_mode` high from N+1 through N+1024, then 0; `fail_cnt`=0; `key_ready` high again from N+1025.
- **Relock:** unlock, then `relock` pulse at cycle 10 of the window → `debug_mode` falls at that edge; IDLE the same edge.
- **Single bad key:** key 16'h0000 → `fail_cnt`=1; `key_ready` low 65 cycles; a `key_valid` held during backoff is not accepted until `key_ready` returns.
- **Three bad keys:** three keys 16'h1234 → `lockout`=1 and `fail_cnt`=3 after the third; a subsequent correct key is never accepted and `debug_mode` stays 0; reset clears everything.
- **Lock request during unlock:** `lock_cfg_done` pulse while UNLOCKED → `lock_out`=1 sticky; `debug_mode` window unaffected; `relock` does not clear `lock_out`.
- **Async reset mid-unlock:** `resetn` low mid-window → `debug_mode`=0, `fail_cnt`=0 and state IDLE immediately, without waiting for a clock edge.
